// File: rtl/sand_brush_cmd_fifo.sv
// Brush command port: host writes stage X/Y/radius/type, COMMIT snapshots them into a
// register-based first-word-fall-through FIFO that drains over a valid/ready stream.
module sand_brush_cmd_fifo #(
   parameter int PAYLOAD_W  = 8,
   parameter int COORD_W    = 8,
   parameter int RADIUS_W   = 8,
   parameter int TYPE_W     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          chipselect,
   input  logic                          write_enable,
   input  logic [2:0]                    action,
   input  logic [PAYLOAD_W-1:0]          payload,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [COORD_W-1:0]            cmd_x,
   output logic [COORD_W-1:0]            cmd_y,
   output logic [RADIUS_W-1:0]           cmd_radius,
   output logic [TYPE_W-1:0]             cmd_type,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          error
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = 2*COORD_W + RADIUS_W + TYPE_W;
   localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ACT_SET_X      = 3'd0,
      ACT_SET_Y      = 3'd1,
      ACT_SET_RADIUS = 3'd2,
      ACT_SET_TYPE   = 3'd3,
      ACT_COMMIT     = 3'd4,
      ACT_CLR_ERROR  = 3'd5
   } action_e;

   // Nonzero bits above the target field make the write illegal.
   function automatic logic over_range(input logic [PAYLOAD_W-1:0] data, input int width);
      return (data >> width) != '0;
   endfunction

   logic [COORD_W-1:0]  x_reg, y_reg;
   logic [RADIUS_W-1:0] r_reg;
   logic [TYPE_W-1:0]   t_reg;
   logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
   logic [ENTRY_W-1:0]  head;
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic                x_ld, y_ld, r_ld, t_ld;
   logic                commit, push, pop, full, set_err, clr_err;

   always_comb begin
      x_ld      = 1'b0;
      y_ld      = 1'b0;
      r_ld      = 1'b0;
      t_ld      = 1'b0;
      commit    = 1'b0;
      set_err   = 1'b0;
      clr_err   = 1'b0;
      full      = (fifo_level == FULL_LVL);
      cmd_valid = (fifo_level != '0);
      pop       = cmd_valid && cmd_ready;
      if (chipselect && write_enable) begin
         case (action_e'(action))
            ACT_SET_X:      if (over_range(payload, COORD_W))  set_err = 1'b1; else x_ld = 1'b1;
            ACT_SET_Y:      if (over_range(payload, COORD_W))  set_err = 1'b1; else y_ld = 1'b1;
            ACT_SET_RADIUS: if (over_range(payload, RADIUS_W)) set_err = 1'b1; else r_ld = 1'b1;
            ACT_SET_TYPE:   if (over_range(payload, TYPE_W))   set_err = 1'b1; else t_ld = 1'b1;
            ACT_COMMIT:     commit  = 1'b1;
            ACT_CLR_ERROR:  clr_err = 1'b1;
            default:        set_err = 1'b1;
         endcase
      end
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      push = commit && (!full || pop);
      if (commit && full && !pop) set_err = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_reg <= '0;
         y_reg <= '0;
         r_reg <= '0;
         t_reg <= '0;
      end else begin
         if (x_ld) x_reg <= payload[COORD_W-1:0];
         if (y_ld) y_reg <= payload[COORD_W-1:0];
         if (r_ld) r_reg <= payload[RADIUS_W-1:0];
         if (t_ld) t_reg <= payload[TYPE_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
         error      <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (clr_err)      error <= 1'b0;
         else if (set_err) error <= 1'b1;
      end
   end

   // Storage needs no reset: it is only observed through cmd_valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {x_reg, y_reg, r_reg, t_reg};
   end

   assign head       = mem[rd_ptr];
   assign cmd_x      = cmd_valid ? head[TYPE_W+RADIUS_W+COORD_W +: COORD_W] : '0;
   assign cmd_y      = cmd_valid ? head[TYPE_W+RADIUS_W +: COORD_W]         : '0;
   assign cmd_radius = cmd_valid ? head[TYPE_W +: RADIUS_W]                 : '0;
   assign cmd_type   = cmd_valid ? head[TYPE_W-1:0]                         : '0;

endmodule

// File: tb/tb_sand_brush_cmd_fifo.sv
// Bench for sand_brush_cmd_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_sand_brush_cmd_fifo;

   localparam int PAYLOAD_W  = 8;
   localparam int COORD_W    = 8;
   localparam int RADIUS_W   = 8;
   localparam int TYPE_W     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int ENT_W      = 2*COORD_W + RADIUS_W + TYPE_W;

   logic                        clk, reset, chipselect, write_enable, cmd_ready;
   logic [2:0]                  action;
   logic [PAYLOAD_W-1:0]        payload;
   logic                        cmd_valid, error;
   logic [COORD_W-1:0]          cmd_x, cmd_y;
   logic [RADIUS_W-1:0]         cmd_radius;
   logic [TYPE_W-1:0]           cmd_type;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   sand_brush_cmd_fifo #(
      .PAYLOAD_W(PAYLOAD_W), .COORD_W(COORD_W), .RADIUS_W(RADIUS_W),
      .TYPE_W(TYPE_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write_enable(write_enable),
      .action(action), .payload(payload), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_radius(cmd_radius), .cmd_type(cmd_type),
      .fifo_level(fifo_level), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: staged fields, a queue of committed commands, sticky error.
   int                 mx, my, mr, mt;
   bit                 merr;
   logic [ENT_W-1:0]   q[$];

   task automatic model_reset();
      mx = 0; my = 0; mr = 0; mt = 0; merr = 0;
      q.delete();
   endtask

   task automatic idle_inputs();
      chipselect = 0; write_enable = 0; action = 0; payload = 0; cmd_ready = 0;
   endtask

   task automatic drive_cycle(input bit cs, input bit we, input int act, input int pl, input bit rdy);
      logic [ENT_W-1:0] e;
      bit do_pop;
      chipselect = cs; write_enable = we; action = act[2:0]; payload = pl[PAYLOAD_W-1:0];
      cmd_ready = rdy;
      do_pop = (q.size() != 0) && rdy;
      if (do_pop) void'(q.pop_front());
      if (cs && we) begin
         case (act)
            0: if ((pl >> COORD_W) != 0)  merr = 1; else mx = pl;
            1: if ((pl >> COORD_W) != 0)  merr = 1; else my = pl;
            2: if ((pl >> RADIUS_W) != 0) merr = 1; else mr = pl;
            3: if ((pl >> TYPE_W) != 0)   merr = 1; else mt = pl;
            4: if (q.size() < FIFO_DEPTH) begin
                  e = {mx[COORD_W-1:0], my[COORD_W-1:0], mr[RADIUS_W-1:0], mt[TYPE_W-1:0]};
                  q.push_back(e);
               end else merr = 1;
            5: merr = 0;
            default: merr = 1;
         endcase
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      model_reset();
   endtask

   task automatic check_model(input string tag);
      logic [ENT_W-1:0] h;
      h = (q.size() != 0) ? q[0] : '0;
      chk({tag, "_valid"}, cmd_valid, q.size() != 0);
      chk({tag, "_level"}, fifo_level, q.size());
      chk({tag, "_error"}, error, merr);
      chk({tag, "_x"}, cmd_x, h[TYPE_W+RADIUS_W+COORD_W +: COORD_W]);
      chk({tag, "_y"}, cmd_y, h[TYPE_W+RADIUS_W +: COORD_W]);
      chk({tag, "_r"}, cmd_radius, h[TYPE_W +: RADIUS_W]);
      chk({tag, "_t"}, cmd_type, h[TYPE_W-1:0]);
   endtask

   typedef struct {
      bit cs, we; int act, pl; bit rdy;
      int v, x, y, r, t, lvl, err;
   } vec_t;

   function automatic vec_t mk(input bit cs, input bit we, input int act, input int pl, input bit rdy,
                               input int v, input int x, input int y, input int r, input int t,
                               input int lvl, input int err);
      vec_t s;
      s.cs = cs; s.we = we; s.act = act; s.pl = pl; s.rdy = rdy;
      s.v = v; s.x = x; s.y = y; s.r = r; s.t = t; s.lvl = lvl; s.err = err;
      return s;
   endfunction

   vec_t tbl[$];

   initial begin
      // Staging then commit, hold with ready low, range error, ignored writes, drain.
      tbl.push_back(mk(1,1,0,'h12,0, 0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,1,'h34,0, 0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,2,5,0,    0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,3,2,0,    0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,4,0,0,    1,'h12,'h34,5,2,1,0));
      for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,0,0, 1,'h12,'h34,5,2,1,0));
      tbl.push_back(mk(1,1,3,7,0,    1,'h12,'h34,5,2,1,1));
      tbl.push_back(mk(1,0,6,0,0,    1,'h12,'h34,5,2,1,1));
      tbl.push_back(mk(0,1,7,0,0,    1,'h12,'h34,5,2,1,1));
      tbl.push_back(mk(1,1,5,0,0,    1,'h12,'h34,5,2,1,0));
      tbl.push_back(mk(0,1,6,0,0,    1,'h12,'h34,5,2,1,0));
      tbl.push_back(mk(1,0,7,0,0,    1,'h12,'h34,5,2,1,0));
      tbl.push_back(mk(1,1,4,0,0,    1,'h12,'h34,5,2,2,0));
      tbl.push_back(mk(0,0,0,0,1,    1,'h12,'h34,5,2,1,0));
      tbl.push_back(mk(1,1,6,0,1,    0,0,0,0,0,0,1));
      tbl.push_back(mk(1,1,5,0,0,    0,0,0,0,0,0,0));

      idle_inputs();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      model_reset();
      chk("rst_valid", cmd_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_error", error, 0);
      chk("rst_x", cmd_x, 0);

      foreach (tbl[i]) begin
         drive_cycle(tbl[i].cs, tbl[i].we, tbl[i].act, tbl[i].pl, tbl[i].rdy);
         chk($sformatf("vec%0d_valid", i), cmd_valid, tbl[i].v);
         chk($sformatf("vec%0d_x", i), cmd_x, tbl[i].x);
         chk($sformatf("vec%0d_y", i), cmd_y, tbl[i].y);
         chk($sformatf("vec%0d_r", i), cmd_radius, tbl[i].r);
         chk($sformatf("vec%0d_t", i), cmd_type, tbl[i].t);
         chk($sformatf("vec%0d_level", i), fifo_level, tbl[i].lvl);
         chk($sformatf("vec%0d_error", i), error, tbl[i].err);
      end

      // Overfill: fifth commit dropped, drain order 1..4.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         drive_cycle(1, 1, 0, i, 0);
         drive_cycle(1, 1, 4, 0, 0);
      end
      chk("ovf_level", fifo_level, 4);
      chk("ovf_error", error, 1);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ovf_pop%0d_valid", i), cmd_valid, 1);
         chk($sformatf("ovf_pop%0d_x", i), cmd_x, i);
         drive_cycle(0, 0, 0, 0, 1);
      end
      chk("ovf_empty_valid", cmd_valid, 0);
      chk("ovf_empty_level", fifo_level, 0);

      // Full FIFO with push and pop together: entry accepted, lands last.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1, 1, 0, 10 + i, 0);
         drive_cycle(1, 1, 4, 0, 0);
      end
      drive_cycle(1, 1, 0, 14, 0);
      drive_cycle(1, 1, 4, 0, 1);
      chk("pp_level", fifo_level, 4);
      chk("pp_error", error, 0);
      for (int i = 11; i <= 14; i++) begin
         chk($sformatf("pp_pop_x%0d", i), cmd_x, i);
         drive_cycle(0, 0, 0, 0, 1);
      end
      chk("pp_empty_valid", cmd_valid, 0);
      check_model("pp_model");

      // Mid-stream reset wins over a simultaneous commit and pop.
      do_reset();
      drive_cycle(1, 1, 0, 9, 0);
      drive_cycle(1, 1, 1, 8, 0);
      drive_cycle(1, 1, 2, 7, 0);
      drive_cycle(1, 1, 3, 1, 0);
      repeat (3) drive_cycle(1, 1, 4, 0, 0);
      drive_cycle(1, 1, 7, 0, 0);
      chk("mrst_pre_level", fifo_level, 3);
      chk("mrst_pre_error", error, 1);
      chipselect = 1; write_enable = 1; action = 3'd4; cmd_ready = 1; reset = 1;
      @(posedge clk); #1;
      reset = 0;
      idle_inputs();
      model_reset();
      chk("mrst_level", fifo_level, 0);
      chk("mrst_valid", cmd_valid, 0);
      chk("mrst_error", error, 0);
      chk("mrst_x", cmd_x, 0);
      drive_cycle(1, 1, 4, 0, 0);
      chk("mrst_commit_valid", cmd_valid, 1);
      chk("mrst_commit_x", cmd_x, 0);
      chk("mrst_commit_y", cmd_y, 0);
      chk("mrst_commit_r", cmd_radius, 0);
      chk("mrst_commit_t", cmd_type, 0);
      chk("mrst_commit_level", fifo_level, 1);

      // Randomized traffic against the reference model.
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         int sel, a, p;
         bit cs, we, rdy;
         sel = $urandom_range(0, 99);
         if      (sel < 15) a = 0;
         else if (sel < 30) a = 1;
         else if (sel < 42) a = 2;
         else if (sel < 55) a = 3;
         else if (sel < 85) a = 4;
         else if (sel < 93) a = 5;
         else               a = 6 + $urandom_range(0, 1);
         p   = (a == 3 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255);
         cs  = ($urandom_range(0, 9) != 0);
         we  = ($urandom_range(0, 9) != 0);
         rdy = (n < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
         drive_cycle(cs, we, a, p, rdy);
         check_model($sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
